// File: rtl/mips_pkg.sv
// Shared datapath constants for the MIPS multicycle core: operation width
// (common to the multiplier and divider) and the divider FSM encoding.
package mips_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_CALC = 2'd1;
  localparam logic [1:0] DIV_FIX  = 2'd2;

endpackage : mips_pkg

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor magnitude when it fits.
module div_step
  import mips_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] dvs_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  logic [WIDTH:0] shifted;

  // The comparison is one bit wider than the operands so a full-range
  // divisor magnitude of 2**(WIDTH-1) is compared exactly.
  always_comb begin
    shifted = {rem_i, bit_i};
    qbit_o  = (shifted >= {1'b0, dvs_i});
    rem_o   = shifted[WIDTH-1:0] - (qbit_o ? dvs_i : '0);
  end

endmodule : div_step

// File: rtl/div_seq.sv
// Multicycle signed divider: LO = quotient, HI = remainder of a / b.
// Optional macro DIV_ZERO_EXC_EN: flag b == 0 and finish immediately instead.
module div_seq
  import mips_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  logic [1:0]       state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [WIDTH-1:0] dvd_q,     dvd_d;   // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0] dvs_q,     dvs_d;
  logic [WIDTH-1:0] rem_q,     rem_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_q,      hi_d;
  logic [WIDTH-1:0] lo_q,      lo_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
`ifdef DIV_ZERO_EXC_EN
  logic             div_zero_q, div_zero_d;
`else
  logic             bzero_q,    bzero_d;
`endif

  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .dvs_i  (dvs_q),
    .bit_i  (dvd_q[WIDTH-1]),
    .rem_o  (step_rem),
    .qbit_o (step_qbit)
  );

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef DIV_ZERO_EXC_EN
    div_zero_d = div_zero_q;
`else
    bzero_d    = bzero_q;
`endif

    case (state_q)
      DIV_IDLE: begin
        if (start) begin
`ifdef DIV_ZERO_EXC_EN
          div_zero_d = (b == '0);
          if (b == '0) begin
            done_d = 1'b1;
          end else begin
`else
          bzero_d = (b == '0);
          begin
`endif
            dvd_d     = a_mag;
            dvs_d     = b_mag;
            rem_d     = '0;
            cnt_d     = '0;
            neg_quo_d = a[WIDTH-1] ^ b[WIDTH-1];
            neg_rem_d = a[WIDTH-1];
            busy_d    = 1'b1;
            state_d   = DIV_CALC;
          end
        end
      end

      DIV_CALC: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[WIDTH-2:0], step_qbit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = DIV_FIX;
      end

      DIV_FIX: begin
        lo_d = neg_quo_q ? -dvd_q : dvd_q;
        hi_d = neg_rem_q ? -rem_q : rem_q;
`ifndef DIV_ZERO_EXC_EN
        if (bzero_q) lo_d = '1;
`endif
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = DIV_IDLE;
      end

      default: state_d = DIV_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef DIV_ZERO_EXC_EN
      div_zero_q <= 1'b0;
`else
      bzero_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef DIV_ZERO_EXC_EN
      div_zero_q <= div_zero_d;
`else
      bzero_q    <= bzero_d;
`endif
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef DIV_ZERO_EXC_EN
  assign div_zero = div_zero_q;
`else
  assign div_zero = 1'b0;
`endif

endmodule : div_seq

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: hand-computed quotient/remainder vectors, latency,
// busy window, ignored restart, reset abort and back-to-back starts.
module tb_div_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a, b, hi, lo;
  logic         busy, done, div_zero;

  int n_vec  = 0;
  int n_miss = 0;
  int lat, busy_cnt, stray;

  always #5 clk = ~clk;

  div_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called on the falling edge just after the accepting edge; lat counts edges
  // from acceptance to the edge that raised done, bounded at 60.
  task automatic wait_done();
    lat      = 0;
    busy_cnt = 0;
    while (!done && lat < 60) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi,
                        input int exp_lat);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~av; b = ~bv;  // operands must be latched at acceptance
    wait_done();
    check({tag, " latency"}, W'(lat), W'(exp_lat));
    check({tag, " lo"}, lo, exp_lo);
    check({tag, " hi"}, hi, exp_hi);
    check({tag, " busy cycles"}, W'(busy_cnt), W'(exp_lat));
    @(negedge clk);
    check({tag, " done pulse width"}, W'(done), W'(0));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    #12;
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    check("reset busy", W'(busy), W'(0));
    check("reset done", W'(done), W'(0));
    check("reset div_zero", W'(div_zero), W'(0));
    @(negedge clk);
    reset = 1'b0;

    run_op("100/7",    32'd100,        32'd7,          32'd14,         32'd2,          33);
    run_op("-100/7",   32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  33);
    run_op("100/-7",   32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          33);
    run_op("min/-1",   32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'h0,          33);
    run_op("min/1",    32'h8000_0000,  32'd1,          32'h8000_0000,  32'h0,          33);
    run_op("19/4",     32'd19,         32'd4,          32'd4,          32'd3,          33);
`ifdef DIV_ZERO_EXC_EN
    run_op("5/0",      32'd5,          32'd0,          32'd4,          32'd3,          0);
    check("5/0 div_zero", W'(div_zero), W'(1));
`else
    run_op("5/0",      32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          33);
    check("5/0 div_zero", W'(div_zero), W'(0));
`endif

    // start re-pulsed while busy must be ignored
    @(negedge clk);
    a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    a = 32'd9; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    check("ignored restart latency", W'(lat), W'(28));
    check("ignored restart lo", lo, 32'd14);
    check("ignored restart hi", hi, 32'd2);
`ifdef DIV_ZERO_EXC_EN
    check("ignored restart div_zero", W'(div_zero), W'(0));
`endif

    // reset mid-operation aborts with everything cleared and no done
    @(negedge clk);
    a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort busy", W'(busy), W'(0));
    check("abort hi", hi, 32'h0);
    check("abort lo", lo, 32'h0);
    check("abort done", W'(done), W'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    stray = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) stray++;
    end
    check("abort no done", W'(stray), W'(0));
    run_op("fresh 100/7", 32'd100, 32'd7, 32'd14, 32'd2, 33);

    // back-to-back: start held high, second op accepted on the done cycle
    @(negedge clk);
    a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    wait_done();
    check("b2b first latency", W'(lat), W'(33));
    check("b2b first lo", lo, 32'd14);
    check("b2b first hi", hi, 32'd2);
    a = 32'hFFFF_FF9C; b = 32'd7;
    @(negedge clk);
    check("b2b second accepted", W'(busy), W'(1));
    start = 1'b0; a = 32'd9; b = 32'd3;
    wait_done();
    check("b2b second latency", W'(lat), W'(33));
    check("b2b second lo", lo, 32'hFFFF_FFF2);
    check("b2b second hi", hi, 32'hFFFF_FFFE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_div_seq
